ptw_ml: RTL and testbench
=========================

Name: ptw_ml

Overview:
Parametrised multi-level hardware page-table walker. It succeeds the fixed two-level Sv32-style walker.
- Serves one TLB miss at a time over valid/ready handshakes.
- Issues one memory read per level over a valid/ready memory port.
- Returns the leaf PTE, the level it was found at (superpage support) and a fault code.
- Sits between the TLB refill logic and the memory/cache arbiter.

Parameters:
VA_WIDTH, 32, virtual address width
PA_WIDTH, 32, physical (memory request) address width
PTE_WIDTH, 32, PTE and memory data width (must be 32 or 64)
LEVELS, 2, number of table levels (1..4)
VPN_BITS, 10, VPN bits per level
PAGE_SHIFT, 12, page offset bits
FLAG_BITS, 10, low PTE bits holding flags; PPN is pte[PTE_WIDTH-1:FLAG_BITS]

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ptw_root_base_i  in  PA_WIDTH  root table physical base; sampled at request accept
ptw_req_valid_i  in  1  walk request valid
ptw_req_ready_o  out  1  walker idle, can accept a request
ptw_vaddr_i  in  VA_WIDTH  virtual address to translate
ptw_resp_valid_o  out  1  walk result valid
ptw_resp_ready_i  in  1  TLB accepts the result
ptw_pte_o  out  PTE_WIDTH  leaf PTE; 0 on fault
ptw_level_o  out  2  level the leaf was found at (0 = last level, LEVELS-1 = root)
ptw_fault_o  out  2  0 none, 1 invalid, 2 no leaf at level 0, 3 misaligned superpage
mem_req_valid_o  out  1  memory read request valid
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  PA_WIDTH  PTE address
mem_resp_valid_i  in  1  memory data valid
mem_resp_ready_o  out  1  walker accepts data
mem_data_i  in  PTE_WIDTH  PTE read data

Behaviour:
- The clock is clk. The reset is rst: asynchronous and active-high. While rst is high, the FSM is IDLE and all registers are cleared.
- Reset values: ptw_req_ready_o=1, all other outputs 0.
- States are IDLE, MEM_REQ, MEM_WAIT and RESP.
- IDLE:
  - ptw_req_ready_o=1.
  - On req_valid&ready, latch vaddr and the root base; set level=LEVELS-1; go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid_o=1.
  - mem_addr_o = base + (vpn[level] << log2(PTE_WIDTH/8)).
  - vpn[l] = vaddr[PAGE_SHIFT+(l+1)*VPN_BITS-1 : PAGE_SHIFT+l*VPN_BITS].
  - Address and valid stay stable until mem_req_ready_i; then go to MEM_WAIT.
- MEM_WAIT:
  - mem_resp_ready_o=1.
  - On mem_resp_valid_i, evaluate mem_data_i. Flags: V=bit0, R=bit1, W=bit2, X=bit3.
    - V=0, or (W=1 & R=0): fault 1.
    - R|X set (leaf) and any PPN bits below level*VPN_BITS nonzero: fault 3.
    - R|X set (leaf) otherwise: success, pte=data.
    - Non-leaf with level==0: fault 2.
    - Non-leaf otherwise: base = {data[PTE_WIDTH-1:FLAG_BITS], FLAG_BITS'b0} truncated/zero-extended to PA_WIDTH; level-1; go to MEM_REQ.
  - On every terminal outcome, go to RESP.
- RESP:
  - ptw_resp_valid_o=1.
  - pte, level and fault are registered and stable until ptw_resp_ready_i.
  - On ptw_resp_ready_i, go to IDLE; ptw_req_ready_o rises the next cycle. No back-to-back accept in the same cycle.
- Latency with zero-wait memory: accept to resp_valid = 2 cycles per level read + 1.
- ptw_req_valid_i is ignored outside IDLE. Memory responses outside MEM_WAIT are ignored. There is never more than one outstanding memory read.
- Reset mid-walk aborts immediately. A memory response arriving after the reset is dropped.

Decomposition:
- Package ptw_pkg holds:
  - state enum;
  - fault-code constants FAULT_NONE/INVALID/NOLEAF/MISALIGN;
  - PTE flag bit indices;
  - function pte_addr(base, vpn) and function vpn_slice(vaddr, level).
- Optional sub-module ptw_pte_check: combinational classification of PTE and level into {leaf, next, fault}. All sequencing stays in ptw_ml.

Test Plan:
All cases use defaults, root=0x400, root[0]=0x00000801, L2@0x800: [0]=0x1000000F, [2]=0x12000007, [3]=0.
- After reset: req_ready=1, mem_req_valid=0, resp_valid=0.
- vaddr 0x00002000 -> mem addrs 0x400 then 0x808; pte=0x12000007, level=0, fault=0.
- Superpage root[3]=0x0040000F, vaddr 0x00C00000 -> single read at 0x40C; pte=0x0040000F, level=1, fault=0.
- Misaligned root[4]=0x0000040F, vaddr 0x01000000 -> pte=0, fault=3. Invalid cases also checked:
  - root[1]=0x12340000, vaddr 0x00400000 -> fault=1, one read only.
  - vaddr 0x00003000 -> fault=1 after 2 reads.
- Non-leaf at last level (L2[5]=0x00000C01), vaddr 0x00005000 -> fault=2. Random mem_req_ready/resp_valid stalls plus resp_ready held low 5 cycles -> outputs stable, results unchanged.
- Assert rst while in MEM_WAIT -> outputs return to reset values asynchronously. The next walk (0x00000000 -> 0x1000000F) passes.

Source files
------------

// File: rtl/ptw_pkg.sv
// Shared types, fault codes, PTE flag positions and address helpers for the
// multi-level page-table walker.
package ptw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } ptw_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_INVALID  = 2'd1;
  localparam logic [1:0] FAULT_NOLEAF   = 2'd2;
  localparam logic [1:0] FAULT_MISALIGN = 2'd3;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  // Helpers work on 64-bit values so any legal width fits; callers resize.
  function automatic logic [63:0] vpn_slice(input logic [63:0] vaddr,
                                            input logic [1:0]  level,
                                            input int          page_shift,
                                            input int          vpn_bits);
    logic [63:0] mask;
    mask = (64'd1 << vpn_bits) - 64'd1;
    return (vaddr >> (page_shift + int'(level) * vpn_bits)) & mask;
  endfunction

  function automatic logic [63:0] pte_addr(input logic [63:0] base,
                                           input logic [63:0] vpn,
                                           input int          pte_shift);
    return base + (vpn << pte_shift);
  endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational PTE classification: leaf, pointer to next level, or fault.
module ptw_pte_check
  import ptw_pkg::*;
#(
  parameter int PTE_WIDTH = 32,
  parameter int FLAG_BITS = 10,
  parameter int VPN_BITS  = 10
) (
  input  logic [PTE_WIDTH-1:0] pte_i,
  input  logic [1:0]           level_i,
  output logic                 leaf_o,
  output logic                 next_o,
  output logic [1:0]           fault_o
);

  localparam logic [PTE_WIDTH-1:0] ONE = {{(PTE_WIDTH-1){1'b0}}, 1'b1};

  logic [PTE_WIDTH-1:0] ppn;
  logic [PTE_WIDTH-1:0] low_mask;

  always_comb begin
    ppn      = pte_i >> FLAG_BITS;
    // A superpage at level L must have its low L*VPN_BITS PPN bits clear.
    low_mask = (ONE << (int'(level_i) * VPN_BITS)) - ONE;
    leaf_o   = 1'b0;
    next_o   = 1'b0;
    fault_o  = FAULT_NONE;
    if (!pte_i[PTE_V] || (pte_i[PTE_W] && !pte_i[PTE_R])) begin
      fault_o = FAULT_INVALID;
    end else if (pte_i[PTE_R] || pte_i[PTE_X]) begin
      if ((ppn & low_mask) != '0) fault_o = FAULT_MISALIGN;
      else                        leaf_o  = 1'b1;
    end else if (level_i == 2'd0) begin
      fault_o = FAULT_NOLEAF;
    end else begin
      next_o = 1'b1;
    end
  end

endmodule

// File: rtl/ptw_ml.sv
// Multi-level page-table walker: one miss at a time, one memory read per level,
// IDLE -> MEM_REQ <-> MEM_WAIT -> RESP -> IDLE.
module ptw_ml
  import ptw_pkg::*;
#(
  parameter int VA_WIDTH   = 32,
  parameter int PA_WIDTH   = 32,
  parameter int PTE_WIDTH  = 32,
  parameter int LEVELS     = 2,
  parameter int VPN_BITS   = 10,
  parameter int PAGE_SHIFT = 12,
  parameter int FLAG_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PA_WIDTH-1:0]  ptw_root_base_i,
  input  logic                 ptw_req_valid_i,
  output logic                 ptw_req_ready_o,
  input  logic [VA_WIDTH-1:0]  ptw_vaddr_i,
  output logic                 ptw_resp_valid_o,
  input  logic                 ptw_resp_ready_i,
  output logic [PTE_WIDTH-1:0] ptw_pte_o,
  output logic [1:0]           ptw_level_o,
  output logic [1:0]           ptw_fault_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [PA_WIDTH-1:0]  mem_addr_o,
  input  logic                 mem_resp_valid_i,
  output logic                 mem_resp_ready_o,
  input  logic [PTE_WIDTH-1:0] mem_data_i
);

  localparam int PTE_SHIFT = (PTE_WIDTH == 64) ? 3 : 2;

  ptw_state_e           state_q, state_d;
  logic [VA_WIDTH-1:0]  vaddr_q, vaddr_d;
  logic [PA_WIDTH-1:0]  base_q, base_d;
  logic [1:0]           level_q, level_d;
  logic [PTE_WIDTH-1:0] pte_q, pte_d;
  logic [1:0]           fault_q, fault_d;

  logic                 chk_leaf, chk_next;
  logic [1:0]           chk_fault;
  logic [PTE_WIDTH-1:0] next_base;

  ptw_pte_check #(
    .PTE_WIDTH (PTE_WIDTH),
    .FLAG_BITS (FLAG_BITS),
    .VPN_BITS  (VPN_BITS)
  ) u_pte_check (
    .pte_i   (mem_data_i),
    .level_i (level_q),
    .leaf_o  (chk_leaf),
    .next_o  (chk_next),
    .fault_o (chk_fault)
  );

  assign next_base = {mem_data_i[PTE_WIDTH-1:FLAG_BITS], {FLAG_BITS{1'b0}}};

  always_comb begin
    state_d          = state_q;
    vaddr_d          = vaddr_q;
    base_d           = base_q;
    level_d          = level_q;
    pte_d            = pte_q;
    fault_d          = fault_q;
    ptw_req_ready_o  = 1'b0;
    ptw_resp_valid_o = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_addr_o       = '0;
    mem_resp_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ptw_req_ready_o = 1'b1;
        if (ptw_req_valid_i) begin
          vaddr_d = ptw_vaddr_i;
          base_d  = ptw_root_base_i;
          level_d = 2'(LEVELS - 1);
          state_d = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o = PA_WIDTH'(pte_addr(64'(base_q),
                                        vpn_slice(64'(vaddr_q), level_q, PAGE_SHIFT, VPN_BITS),
                                        PTE_SHIFT));
        if (mem_req_ready_i) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          if (chk_next) begin
            base_d  = PA_WIDTH'(next_base);
            level_d = level_q - 2'd1;
            state_d = ST_MEM_REQ;
          end else begin
            pte_d   = chk_leaf ? mem_data_i : '0;
            fault_d = chk_fault;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        ptw_resp_valid_o = 1'b1;
        if (ptw_resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vaddr_q <= '0;
      base_q  <= '0;
      level_q <= '0;
      pte_q   <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      base_q  <= base_d;
      level_q <= level_d;
      pte_q   <= pte_d;
      fault_q <= fault_d;
    end
  end

  assign ptw_pte_o   = pte_q;
  assign ptw_level_o = level_q;
  assign ptw_fault_o = fault_q;

endmodule

// File: tb/tb_ptw_ml.sv
// Randomised self-checking bench for ptw_ml against a behavioural walk model.
module tb_ptw_ml;

  localparam logic [31:0] ROOT = 32'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ptw_root_base_i;
  logic        ptw_req_valid_i;
  logic        ptw_req_ready_o;
  logic [31:0] ptw_vaddr_i;
  logic        ptw_resp_valid_o;
  logic        ptw_resp_ready_i;
  logic [31:0] ptw_pte_o;
  logic [1:0]  ptw_level_o;
  logic [1:0]  ptw_fault_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i;

  ptw_ml dut (
    .clk              (clk),
    .rst              (rst),
    .ptw_root_base_i  (ptw_root_base_i),
    .ptw_req_valid_i  (ptw_req_valid_i),
    .ptw_req_ready_o  (ptw_req_ready_o),
    .ptw_vaddr_i      (ptw_vaddr_i),
    .ptw_resp_valid_o (ptw_resp_valid_o),
    .ptw_resp_ready_i (ptw_resp_ready_i),
    .ptw_pte_o        (ptw_pte_o),
    .ptw_level_o      (ptw_level_o),
    .ptw_fault_o      (ptw_fault_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_data_i       (mem_data_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem_m [int unsigned];
  logic [31:0] exp_addrs[$];
  logic [31:0] act_addrs[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  // Walk the table as the rules describe it: index, fetch, classify, descend.
  function automatic void model_walk(input logic [31:0] va, output logic [31:0] pte,
                                     output logic [1:0] lvl_o, output logic [1:0] flt);
    logic [31:0] base;
    logic [31:0] d;
    logic [31:0] a;
    int unsigned idx;
    int unsigned ppn;
    base = ROOT;
    pte = 32'h0; lvl_o = 2'd0; flt = 2'd0;
    exp_addrs.delete();
    for (int lvl = 1; lvl >= 0; lvl--) begin
      idx = (va >> (12 + 10 * lvl)) % 1024;
      a = base + idx * 4;
      exp_addrs.push_back(a);
      d = mem_rd(a);
      lvl_o = 2'(lvl);
      if (!d[0] || (d[2] && !d[1])) begin flt = 2'd1; return; end
      if (d[1] || d[3]) begin
        ppn = d >> 10;
        if (ppn % (1 << (10 * lvl)) != 0) flt = 2'd3;
        else pte = d;
        return;
      end
      if (lvl == 0) begin flt = 2'd2; return; end
      base = (d >> 10) << 10;
    end
  endfunction

  // Memory responder: one outstanding read, optional random stalls.
  bit          stall_en = 1'b0;
  int          fixed_delay = -1;
  bit          bfm_flush = 1'b0;
  bit          out_pend = 1'b0;
  int          delay_cnt = 0;
  logic [31:0] out_data = 32'h0;
  bit          p_req_v = 1'b0, p_req_r = 1'b0, p_rsp_v = 1'b0, p_rsp_r = 1'b0;
  logic [31:0] p_addr = 32'h0;

  initial begin
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_data_i       = 32'h0;
    forever begin
      @(negedge clk);
      if (bfm_flush) begin out_pend = 1'b0; bfm_flush = 1'b0; end
      if (p_rsp_v && p_rsp_r) out_pend = 1'b0;
      if (p_req_v && p_req_r) begin
        act_addrs.push_back(p_addr);
        out_pend  = 1'b1;
        out_data  = mem_rd(p_addr);
        delay_cnt = (fixed_delay >= 0) ? fixed_delay : (stall_en ? int'($urandom_range(0, 3)) : 0);
      end else if (p_req_v && !rst) begin
        chk("mreq_hold", {31'h0, mem_req_valid_o, mem_addr_o}, {31'h0, 1'b1, p_addr});
      end
      mem_req_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_pend && delay_cnt > 0) begin
        delay_cnt--;
        mem_resp_valid_i = 1'b0;
      end else begin
        mem_resp_valid_i = out_pend;
      end
      mem_data_i = out_pend ? out_data : $urandom;
      p_req_v = mem_req_valid_o;
      p_req_r = mem_req_ready_i;
      p_addr  = mem_addr_o;
      p_rsp_v = mem_resp_valid_i;
      p_rsp_r = mem_resp_ready_o;
    end
  end

  task automatic wait_ready_and_request(input logic [31:0] va, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ptw_req_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("req_ready_timeout", 0, 1); return; end
    ptw_vaddr_i     = va;
    ptw_req_valid_i = 1'b1;
  endtask

  task automatic walk(input logic [31:0] va, input int hold);
    logic [31:0] e_pte;
    logic [1:0]  e_lvl, e_flt;
    bit          ok;
    int          n;
    model_walk(va, e_pte, e_lvl, e_flt);
    act_addrs.delete();
    wait_ready_and_request(va, ok);
    if (!ok) return;
    ok = 1'b0;
    for (n = 1; n <= 300; n++) begin
      @(negedge clk);
      ptw_req_valid_i = 1'b0;
      ptw_vaddr_i     = $urandom;
      if (ptw_resp_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("resp_timeout", 0, 1); return; end
    if (!stall_en) chk("latency", 64'(n), 64'(2 * exp_addrs.size() + 1));
    chk("no_accept_in_resp", {63'h0, ptw_req_ready_o}, 64'h0);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {63'h0, ptw_resp_valid_o}, 64'h1);
      chk("hold_pte", {32'h0, ptw_pte_o}, {32'h0, e_pte});
      chk("hold_fault", {62'h0, ptw_fault_o}, {62'h0, e_flt});
      @(negedge clk);
    end
    chk("pte", {32'h0, ptw_pte_o}, {32'h0, e_pte});
    chk("fault", {62'h0, ptw_fault_o}, {62'h0, e_flt});
    if (e_flt == 2'd0) chk("level", {62'h0, ptw_level_o}, {62'h0, e_lvl});
    chk("num_reads", 64'(act_addrs.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && i < act_addrs.size(); i++)
      chk("read_addr", {32'h0, act_addrs[i]}, {32'h0, exp_addrs[i]});
    ptw_resp_ready_i = 1'b1;
    @(negedge clk);
    ptw_resp_ready_i = 1'b0;
    chk("resp_drop", {63'h0, ptw_resp_valid_o}, 64'h0);
    chk("ready_back", {63'h0, ptw_req_ready_o}, 64'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {63'h0, ptw_req_ready_o}, 64'h1);
    chk({tag, "_mem_req_valid"}, {63'h0, mem_req_valid_o}, 64'h0);
    chk({tag, "_resp_valid"}, {63'h0, ptw_resp_valid_o}, 64'h0);
    chk({tag, "_mem_resp_ready"}, {63'h0, mem_resp_ready_o}, 64'h0);
    chk({tag, "_mem_addr"}, {32'h0, mem_addr_o}, 64'h0);
    chk({tag, "_pte"}, {32'h0, ptw_pte_o}, 64'h0);
    chk({tag, "_level"}, {62'h0, ptw_level_o}, 64'h0);
    chk({tag, "_fault"}, {62'h0, ptw_fault_o}, 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] va;
    mem_m[32'h400] = 32'h00000801;
    mem_m[32'h404] = 32'h12340000;
    mem_m[32'h40C] = 32'h0040000F;
    mem_m[32'h410] = 32'h0000040F;
    mem_m[32'h800] = 32'h1000000F;
    mem_m[32'h808] = 32'h12000007;
    mem_m[32'h80C] = 32'h00000000;
    mem_m[32'h814] = 32'h00000C01;

    rst = 1'b1;
    ptw_root_base_i  = ROOT;
    ptw_req_valid_i  = 1'b0;
    ptw_vaddr_i      = 32'h0;
    ptw_resp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    walk(32'h00002000, 0);
    walk(32'h00C00000, 0);
    walk(32'h01000000, 0);
    walk(32'h00400000, 0);
    walk(32'h00003000, 0);
    walk(32'h00005000, 0);

    stall_en = 1'b1;
    walk(32'h00005000, 5);
    walk(32'h00002000, 5);
    for (int i = 0; i < 30; i++) begin
      va = {10'($urandom_range(0, 5)), 10'($urandom_range(0, 7)), 12'($urandom)};
      walk(va, int'($urandom_range(0, 3)));
    end
    stall_en = 1'b0;

    // Abort a walk while it waits for memory; the late response must be dropped.
    fixed_delay = 6;
    wait_ready_and_request(32'h00002000, ok);
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        ptw_req_valid_i = 1'b0;
        if (mem_resp_ready_o) begin ok = 1'b1; break; end
      end
      chk("reached_mem_wait", {63'h0, ok}, 64'h1);
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("post_rst_resp_valid", {63'h0, ptw_resp_valid_o}, 64'h0);
        chk("post_rst_mem_req", {63'h0, mem_req_valid_o}, 64'h0);
        chk("post_rst_req_ready", {63'h0, ptw_req_ready_o}, 64'h1);
      end
    end
    ptw_req_valid_i = 1'b0;
    fixed_delay = -1;
    bfm_flush = 1'b1;
    repeat (2) @(negedge clk);
    walk(32'h00000000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
